score_ctrl: RTL and testbench

SCORE_CTRL -- requirements
Module: score_ctrl

---
 rtl/score_ctrl.sv | 135 +++++++++++++
 tb/tb_score_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_ctrl.sv
// score_ctrl: per-frame score, lives, invincibility and bomb bookkeeping for the game
module score_ctrl #(
    parameter int INIT_LIVES = 3,
    parameter int INV_FRAMES = 120,
    parameter int MAX_BOMBS  = 3
) (
    input  logic        clk_vga,
    input  logic        rst_n,
    input  logic        frame_start_i,
    input  logic [2:0]  game_status_i,
    input  logic        crash_enemy_bullet_i,
    input  logic        crash_me_enemy_i,
    input  logic        crash_me_bonus_i,
    input  logic        bomb_key_i,
    output logic [15:0] score_o,
    output logic [1:0]  lives_o,
    output logic [1:0]  bombs_o,
    output logic        bomb_fire_o,
    output logic        invincible_o,
    output logic        gameover_o
);
    localparam logic [2:0] ST_RUN     = 3'b001;
    localparam logic [2:0] ST_PRERUN  = 3'b010;
    localparam logic [1:0] LIVES_INIT = 2'(INIT_LIVES);
    localparam logic [1:0] BOMBS_MAX  = 2'(MAX_BOMBS);
    localparam logic [7:0] INV_LOAD   = 8'(INV_FRAMES);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t      state;
    logic        hit_e;
    logic        hit_me;
    logic        hit_bonus;
    logic        prev_bonus;
    logic        key_d;
    logic [7:0]  inv_cnt;
    logic        run;
    logic        eval;
    logic        restart;
    logic        fire;
    logic        lose;
    logic        bonus_add;
    logic [1:0]  bombs_dec;
    logic [15:0] score_inc;

    // Four-digit BCD increment that sticks at 9999
    function automatic logic [15:0] bcd_inc(input logic [15:0] s);
        logic [15:0] r;
        logic        c;
        r = s;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return (s == 16'h9999) ? s : r;
    endfunction

    // Decode the per-cycle events: frame evaluation, bomb fire, life loss, bonus pickup
    always_comb begin
        run       = state == PLAY && game_status_i == ST_RUN;
        eval      = run && frame_start_i;
        restart   = state != IDLE && game_status_i == ST_PRERUN;
        fire      = run && bomb_key_i && !key_d && bombs_o != 2'd0;
        lose      = eval && hit_me && inv_cnt == 8'd0;
        bonus_add = eval && hit_bonus && !prev_bonus;
        bombs_dec = bombs_o - {1'b0, fire};
        score_inc = bcd_inc(score_o);
    end

    // Game FSM with sticky frame flags; every output is a register
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            score_o      <= 16'h0000;
            lives_o      <= LIVES_INIT;
            bombs_o      <= 2'd0;
            bomb_fire_o  <= 1'b0;
            invincible_o <= 1'b0;
            gameover_o   <= 1'b0;
            hit_e        <= 1'b0;
            hit_me       <= 1'b0;
            hit_bonus    <= 1'b0;
            prev_bonus   <= 1'b0;
            key_d        <= 1'b0;
            inv_cnt      <= 8'd0;
        end else begin
            key_d       <= bomb_key_i;
            bomb_fire_o <= fire;
            if (restart) begin
                state        <= IDLE;
                score_o      <= 16'h0000;
                lives_o      <= LIVES_INIT;
                bombs_o      <= 2'd0;
                invincible_o <= 1'b0;
                gameover_o   <= 1'b0;
                hit_e        <= 1'b0;
                hit_me       <= 1'b0;
                hit_bonus    <= 1'b0;
                prev_bonus   <= 1'b0;
                inv_cnt      <= 8'd0;
            end else begin
                hit_e     <= state == PLAY && ((hit_e && !frame_start_i) || (run && crash_enemy_bullet_i));
                hit_me    <= state == PLAY && ((hit_me && !frame_start_i) || (run && crash_me_enemy_i));
                hit_bonus <= state == PLAY && ((hit_bonus && !frame_start_i) || (run && crash_me_bonus_i));
                bombs_o   <= (bonus_add && bombs_dec < BOMBS_MAX) ? bombs_dec + 2'd1 : bombs_dec;
                if (state == IDLE && game_status_i == ST_RUN)
                    state <= PLAY;
                if (eval) begin
                    prev_bonus <= hit_bonus;
                    if (hit_e)
                        score_o <= score_inc;
                    if (lose) begin
                        lives_o      <= lives_o - 2'd1;
                        inv_cnt      <= INV_LOAD;
                        invincible_o <= 1'b1;
                        if (lives_o == 2'd1) begin
                            state      <= OVER;
                            gameover_o <= 1'b1;
                        end
                    end else if (inv_cnt != 8'd0) begin
                        inv_cnt      <= inv_cnt - 8'd1;
                        invincible_o <= inv_cnt != 8'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_score_ctrl.sv
// tb_score_ctrl: scoreboard bench for score_ctrl against a game-rule reference model
module tb_score_ctrl;
    localparam int INIT = 3;
    localparam int INV  = 120;
    localparam int MAXB = 3;

    logic        clk_vga;
    logic        rst_n;
    logic        frame_start;
    logic [2:0]  game_status;
    logic        crash_e;
    logic        crash_m;
    logic        crash_b;
    logic        bomb_key;
    logic [15:0] score_o;
    logic [1:0]  lives_o;
    logic [1:0]  bombs_o;
    logic        bomb_fire_o;
    logic        invincible_o;
    logic        gameover_o;

    int total = 0;
    int bad   = 0;
    logic [22:0] q[$];

    int m_score, m_lives, m_bombs, m_inv, m_mode;
    bit m_he, m_hm, m_hb, m_prevb, m_key, m_fire;

    score_ctrl #(.INIT_LIVES(INIT), .INV_FRAMES(INV), .MAX_BOMBS(MAXB)) dut (
        .clk_vga(clk_vga),
        .rst_n(rst_n),
        .frame_start_i(frame_start),
        .game_status_i(game_status),
        .crash_enemy_bullet_i(crash_e),
        .crash_me_enemy_i(crash_m),
        .crash_me_bonus_i(crash_b),
        .bomb_key_i(bomb_key),
        .score_o(score_o),
        .lives_o(lives_o),
        .bombs_o(bombs_o),
        .bomb_fire_o(bomb_fire_o),
        .invincible_o(invincible_o),
        .gameover_o(gameover_o)
    );

    initial clk_vga = 1'b0;
    always #5 clk_vga = ~clk_vga;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [22:0] expv();
        return {to_bcd(m_score), 2'(m_lives), 2'(m_bombs), m_fire, m_inv != 0, m_mode == 2};
    endfunction

    // mode: 0 waiting for run, 1 playing, 2 game over
    task automatic m_init();
        m_score = 0; m_lives = INIT; m_bombs = 0; m_inv = 0; m_mode = 0;
        m_he = 0; m_hm = 0; m_hb = 0; m_prevb = 0; m_fire = 0;
    endtask

    task automatic model_step(input bit r, input bit fs, input int st, input bit ce, input bit cm,
                              input bit cb, input bit k);
        bit run, fire, he, hm, hb;
        if (!r) begin
            m_init();
            m_key = 0;
        end else begin
            run  = m_mode == 1 && st == 1;
            fire = run && k && !m_key && m_bombs > 0;
            m_key = k;
            m_fire = fire;
            if (m_mode != 0 && st == 2) begin
                m_init();
            end else begin
                he = m_he; hm = m_hm; hb = m_hb;
                if (m_mode == 1) begin
                    m_he = (fs ? 1'b0 : m_he) | (run && ce);
                    m_hm = (fs ? 1'b0 : m_hm) | (run && cm);
                    m_hb = (fs ? 1'b0 : m_hb) | (run && cb);
                end else begin
                    m_he = 0; m_hm = 0; m_hb = 0;
                end
                if (m_mode == 0) begin
                    if (st == 1) m_mode = 1;
                end else if (m_mode == 1) begin
                    if (fire) m_bombs = m_bombs - 1;
                    if (run && fs) begin
                        if (he) m_score = (m_score < 9999) ? m_score + 1 : 9999;
                        if (hb && !m_prevb && m_bombs < MAXB) m_bombs = m_bombs + 1;
                        m_prevb = hb;
                        if (hm && m_inv == 0) begin
                            m_lives = m_lives - 1;
                            m_inv = INV;
                            if (m_lives == 0) m_mode = 2;
                        end else if (m_inv > 0) begin
                            m_inv = m_inv - 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit fs, input logic [2:0] st, input bit ce, input bit cm,
                       input bit cb, input bit k);
        @(negedge clk_vga);
        rst_n = r; frame_start = fs; game_status = st;
        crash_e = ce; crash_m = cm; crash_b = cb; bomb_key = k;
        model_step(r, fs, int'(st), ce, cm, cb, k);
        q.push_back(expv());
    endtask

    task automatic frame(input int len, input bit ce, input bit cm, input bit cb);
        cyc(1, 1, 3'b001, ce, cm, cb, 0);
        for (int i = 1; i < len; i++) cyc(1, 0, 3'b001, ce, cm, cb, 0);
    endtask

    task automatic settle();
        @(posedge clk_vga);
        #1;
    endtask

    // Monitor: one expected output word per clocked cycle
    initial begin
        logic [22:0] e, g;
        forever begin
            @(posedge clk_vga);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                g = {score_o, lives_o, bombs_o, bomb_fire_o, invincible_o, gameover_o};
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t got score=%h lives=%0d bombs=%0d fire=%b inv=%b over=%b exp score=%h lives=%0d bombs=%0d fire=%b inv=%b over=%b",
                             $time, g[22:7], g[6:5], g[4:3], g[2], g[1], g[0],
                             e[22:7], e[6:5], e[4:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        bit k;
        int r;
        logic [2:0] st;
        m_init();
        m_key = 0;
        rst_n = 0; frame_start = 0; game_status = 3'b000;
        crash_e = 0; crash_m = 0; crash_b = 0; bomb_key = 0;
        repeat (3) cyc(0, 0, 3'b000, 0, 0, 0, 0);
        settle();
        chk("reset_score", score_o, 16'h0000);
        chk("reset_lives", lives_o, 2'd3);
        chk("reset_bombs", bombs_o, 2'd0);
        cyc(1, 0, 3'b001, 0, 0, 0, 0);
        frame(500, 1, 0, 0);
        settle();
        chk("score_before_eval", score_o, 16'h0000);
        cyc(1, 1, 3'b001, 0, 0, 0, 0);
        settle();
        chk("score_one_hit_frame", score_o, 16'h0001);
        repeat (99) frame(2, 1, 0, 0);
        cyc(1, 1, 3'b001, 0, 0, 0, 0);
        settle();
        chk("score_carry_0100", score_o, 16'h0100);
        repeat (9905) frame(2, 1, 0, 0);
        cyc(1, 1, 3'b001, 0, 0, 0, 0);
        settle();
        chk("score_sat_9999", score_o, 16'h9999);
        frame(2, 0, 1, 0);
        frame(2, 0, 1, 0);
        settle();
        chk("lives_after_f1", lives_o, 2'd2);
        chk("inv_after_f1", invincible_o, 1'b1);
        frame(2, 0, 0, 0);
        settle();
        chk("lives_after_f2", lives_o, 2'd2);
        repeat (118) frame(2, 0, 0, 0);
        frame(2, 0, 1, 0);
        settle();
        chk("inv_expired", invincible_o, 1'b0);
        chk("lives_before_f122", lives_o, 2'd2);
        frame(2, 0, 0, 0);
        settle();
        chk("lives_after_f122", lives_o, 2'd1);
        repeat (119) frame(2, 0, 0, 0);
        frame(2, 0, 1, 0);
        frame(2, 0, 0, 0);
        settle();
        chk("gameover", gameover_o, 1'b1);
        chk("over_lives", lives_o, 2'd0);
        cyc(1, 1, 3'b001, 1, 1, 1, 1);
        settle();
        chk("over_hold_score", score_o, 16'h9999);
        cyc(1, 0, 3'b010, 0, 0, 0, 0);
        settle();
        chk("restart_lives", lives_o, 2'd3);
        chk("restart_score", score_o, 16'h0000);
        chk("restart_over", gameover_o, 1'b0);
        cyc(1, 0, 3'b001, 0, 0, 0, 0);
        repeat (5) frame(2, 0, 0, 1);
        frame(2, 0, 0, 0);
        settle();
        chk("bonus_once", bombs_o, 2'd1);
        cyc(1, 0, 3'b001, 0, 0, 0, 1);
        settle();
        chk("fire_pulse", bomb_fire_o, 1'b1);
        chk("fire_bombs", bombs_o, 2'd0);
        cyc(1, 0, 3'b001, 0, 0, 0, 1);
        settle();
        chk("fire_one_cycle", bomb_fire_o, 1'b0);
        cyc(1, 0, 3'b001, 0, 0, 0, 0);
        cyc(1, 0, 3'b001, 0, 0, 0, 1);
        settle();
        chk("fire_empty", bomb_fire_o, 1'b0);
        cyc(1, 1, 3'b001, 1, 0, 1, 0);
        cyc(1, 0, 3'b001, 1, 0, 1, 0);
        cyc(1, 1, 3'b001, 1, 1, 1, 0);
        settle();
        chk("pre_reset_score", score_o, 16'h0001);
        chk("pre_reset_bombs", bombs_o, 2'd1);
        cyc(0, 0, 3'b001, 1, 1, 1, 0);
        #1;
        chk("async_rst_score", score_o, 16'h0000);
        chk("async_rst_bombs", bombs_o, 2'd0);
        chk("async_rst_lives", lives_o, 2'd3);
        cyc(0, 0, 3'b001, 0, 0, 0, 0);
        cyc(1, 0, 3'b001, 0, 0, 0, 0);
        cyc(1, 1, 3'b001, 0, 0, 0, 0);
        settle();
        chk("no_eval_after_rst", score_o, 16'h0000);
        chk("no_loss_after_rst", lives_o, 2'd3);
        k = 0;
        for (int n = 0; n < 4000; n++) begin
            r = int'($urandom_range(0, 99));
            st = (r < 85) ? 3'b001 : (r < 92) ? 3'b000 : (r < 95) ? 3'b011 : 3'b010;
            if ($urandom_range(0, 3) == 0) k = !k;
            cyc($urandom_range(0, 999) != 0, $urandom_range(0, 3) == 0, st,
                $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, k);
        end
        repeat (3) @(posedge clk_vga);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
